// File: rtl/math_computer_result_buffer_if.sv
// Handshake bundle between the math computer, the result buffer and its consumer.
// The slave modport is the buffer's view; the master modport is the producer/consumer view.
interface math_computer_result_buffer_if #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic                  in_valid;
    logic [DATA_WIDTH-1:0] in_result;
    logic                  out_valid;
    logic [DATA_WIDTH-1:0] out_result;
    logic                  out_ready;
    logic [CW-1:0]         count;
    logic                  full;
    logic                  empty;
    logic                  overflow;
    logic                  clear_overflow;

    modport slave (
        input  in_valid, in_result, out_ready, clear_overflow,
        output out_valid, out_result, count, full, empty, overflow
    );

    modport master (
        output in_valid, in_result, out_ready, clear_overflow,
        input  out_valid, out_result, count, full, empty, overflow
    );
endinterface

// File: rtl/math_computer_result_buffer.sv
// First-word-fall-through result FIFO with no upstream backpressure: words arriving
// while full are dropped and latched into a sticky overflow flag.
module math_computer_result_buffer #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 8
) (
    input logic                          clk,
    input logic                          rst,
    math_computer_result_buffer_if.slave bus
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overflow_q, overflow_d;

    logic is_empty;
    logic is_full;
    logic pop;
    logic push;
    logic drop;

    assign is_empty = (count_q == '0);
    assign is_full  = (count_q == CW'(DEPTH));

    // A pop frees a slot in the same edge, so a full buffer still accepts a word when drained.
    assign pop  = !is_empty && bus.out_ready;
    assign push = bus.in_valid && (!is_full || pop);
    assign drop = bus.in_valid && is_full && !pop;

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase

        // A drop on the same edge as a clear wins, so no lost word goes unreported.
        if (drop) begin
            overflow_d = 1'b1;
        end else if (bus.clear_overflow) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Storage is deliberately left out of reset; stale words are masked by count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q] <= bus.in_result;
        end
    end

    assign bus.out_valid  = !is_empty;
    assign bus.out_result = mem[rd_ptr_q];
    assign bus.count      = count_q;
    assign bus.full       = is_full;
    assign bus.empty      = is_empty;
    assign bus.overflow   = overflow_q;

endmodule

// File: tb/tb_math_computer_result_buffer.sv
// Directed bench for the result buffer: reset, single word, fill/overflow, full push+pop,
// clear priority, async reset mid-stream and a randomly throttled 20-word stream.
module tb_math_computer_result_buffer;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    math_computer_result_buffer_if #(.DATA_WIDTH(32), .DEPTH(8)) bus ();

    math_computer_result_buffer #(.DATA_WIDTH(32), .DEPTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs are sampled 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_word(input logic [31:0] w);
        bus.in_valid  = 1'b1;
        bus.in_result = w;
        step();
        bus.in_valid  = 1'b0;
    endtask

    logic [31:0] q[$];
    logic [31:0] exp_w;
    int          sent;
    int          rcvd;
    int          mcount;
    int          cyc;
    logic        rdy;
    logic        vin;

    initial begin
        checks   = 0;
        failures = 0;
        rst                = 1'b1;
        bus.in_valid       = 1'b0;
        bus.in_result      = '0;
        bus.out_ready      = 1'b0;
        bus.clear_overflow = 1'b0;
        #3;
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_empty", 32'(bus.empty), 32'd1);
        chk("rst_full", 32'(bus.full), 32'd0);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_overflow", 32'(bus.overflow), 32'd0);
        step();
        rst = 1'b0;
        step();

        // Single word
        push_word(32'h0000002A);
        chk("single_valid", 32'(bus.out_valid), 32'd1);
        chk("single_data", bus.out_result, 32'h0000002A);
        chk("single_count", 32'(bus.count), 32'd1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        chk("single_empty", 32'(bus.empty), 32'd1);

        // Fill and overflow
        for (int i = 1; i <= 9; i++) begin
            push_word(32'(i));
            if (i == 8) begin
                chk("fill_full", 32'(bus.full), 32'd1);
                chk("fill_count8", 32'(bus.count), 32'd8);
                chk("fill_no_ovf", 32'(bus.overflow), 32'd0);
            end
        end
        chk("fill_ovf", 32'(bus.overflow), 32'd1);
        chk("fill_count_after_drop", 32'(bus.count), 32'd8);
        bus.out_ready = 1'b1;
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("fill_pop%0d", i), bus.out_result, 32'(i));
            step();
        end
        chk("fill_drained_empty", 32'(bus.empty), 32'd1);
        // out_ready while empty must not move anything
        step();
        chk("empty_ready_count", 32'(bus.count), 32'd0);
        chk("empty_ready_valid", 32'(bus.out_valid), 32'd0);
        bus.out_ready = 1'b0;
        bus.clear_overflow = 1'b1;
        step();
        bus.clear_overflow = 1'b0;
        chk("clear_ovf", 32'(bus.overflow), 32'd0);

        // Push into empty with out_ready high: no pop, word appears next cycle
        bus.out_ready = 1'b1;
        push_word(32'h55);
        bus.out_ready = 1'b0;
        chk("push_empty_rdy_count", 32'(bus.count), 32'd1);
        chk("push_empty_rdy_data", bus.out_result, 32'h55);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // Full with simultaneous push and pop
        for (int i = 0; i < 8; i++) push_word(32'h10 + 32'(i));
        chk("fp_full", 32'(bus.full), 32'd1);
        bus.out_ready = 1'b1;
        push_word(32'h18);
        chk("fp_count", 32'(bus.count), 32'd8);
        chk("fp_no_ovf", 32'(bus.overflow), 32'd0);
        for (int i = 1; i <= 8; i++) begin
            chk($sformatf("fp_pop%0d", i), bus.out_result, 32'h10 + 32'(i));
            step();
        end
        bus.out_ready = 1'b0;
        chk("fp_empty", 32'(bus.empty), 32'd1);

        // Drop and clear on the same edge
        for (int i = 0; i < 8; i++) push_word(32'h20 + 32'(i));
        bus.clear_overflow = 1'b1;
        push_word(32'h28);
        chk("clr_prio_ovf", 32'(bus.overflow), 32'd1);
        chk("clr_prio_count", 32'(bus.count), 32'd8);
        step();
        bus.clear_overflow = 1'b0;
        chk("clr_next_ovf", 32'(bus.overflow), 32'd0);

        // Reset mid-stream with five words held
        bus.out_ready = 1'b1;
        step(); step(); step();
        bus.out_ready = 1'b0;
        chk("mid_count5", 32'(bus.count), 32'd5);
        chk("mid_head", bus.out_result, 32'h23);
        #2;
        rst = 1'b1;
        #1;
        chk("async_empty", 32'(bus.empty), 32'd1);
        chk("async_valid", 32'(bus.out_valid), 32'd0);
        chk("async_count", 32'(bus.count), 32'd0);
        step();
        rst = 1'b0;
        push_word(32'h7);
        chk("post_rst_data", bus.out_result, 32'h7);
        chk("post_rst_count", 32'(bus.count), 32'd1);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;

        // Wrap-around stream with random consumer throttling
        sent = 0; rcvd = 0; mcount = 0; cyc = 0;
        while (rcvd < 20 && cyc < 400) begin
            rdy = 1'($urandom_range(0, 1));
            vin = (sent < 20) && (mcount < 8 || (rdy && mcount > 0));
            bus.out_ready = rdy;
            bus.in_valid  = vin;
            bus.in_result = 32'hA00 + 32'(sent);
            if (rdy && mcount > 0) begin
                exp_w = q.pop_front();
                chk("wrap_data", bus.out_result, exp_w);
                rcvd++;
                mcount--;
            end
            if (vin) begin
                q.push_back(32'hA00 + 32'(sent));
                sent++;
                mcount++;
            end
            step();
            chk("wrap_count", 32'(bus.count), 32'(mcount));
            chk("wrap_le8", 32'(bus.count <= 4'd8), 32'd1);
            cyc++;
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        chk("wrap_received", 32'(rcvd), 32'd20);
        chk("wrap_end_empty", 32'(bus.empty), 32'd1);
        chk("wrap_ovf", 32'(bus.overflow), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/math_computer_result_buffer.md
MATH_COMPUTER_RESULT_BUFFER -- requirements
Module: math_computer_result_buffer

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset; the clock port is clk and the reset port is rst.
REQ-002 Parameter DATA_WIDTH, default 32, SHALL set the result word width in bits.
REQ-003 Parameter DEPTH, default 8, SHALL set the number of storage entries; legal values are powers of two, 2 to 256.
REQ-004 Port clk, input, 1 bit, SHALL be the clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1 bit, SHALL be the asynchronous active-high reset.
REQ-006 Port in_valid, input, 1 bit, SHALL indicate a result word from the upstream math computer; there is no upstream ready.
REQ-007 Port in_result, input, DATA_WIDTH bits, SHALL carry the result word, sampled when in_valid=1.
REQ-008 Port out_valid, output, 1 bit, SHALL indicate that out_result holds the oldest stored word.
REQ-009 Port out_result, output, DATA_WIDTH bits, SHALL carry the oldest stored word.
REQ-010 Port out_ready, input, 1 bit, SHALL indicate that the consumer accepts out_result.
REQ-011 Port count, output, clog2(DEPTH)+1 bits, SHALL give the number of stored words.
REQ-012 Port full, output, 1 bit, SHALL be 1 when count=DEPTH.
REQ-013 Port empty, output, 1 bit, SHALL be 1 when count=0.
REQ-014 Port overflow, output, 1 bit, SHALL be a sticky flag for a dropped word.
REQ-015 Port clear_overflow, input, 1 bit, SHALL clear overflow.

Function
REQ-016 Push SHALL occur on a rising edge with in_valid=1 and either full=0 or a pop in the same cycle.
REQ-017 Pop SHALL occur on a rising edge with out_valid=1 and out_ready=1.
REQ-018 Storage SHALL be a circular buffer with write and read pointers of clog2(DEPTH) bits, wrapping from DEPTH-1 to 0.
REQ-019 Output SHALL be first-word-fall-through: out_valid = not empty, and out_result = mem[rd_ptr] combinationally.
REQ-020 Latency SHALL be one cycle: a word pushed into an empty buffer at edge N is presented with out_valid=1 after edge N.
REQ-021 Simultaneous push and pop SHALL leave count unchanged and advance both pointers, including when full=1.
REQ-022 When full=1 and in_valid=1 with no pop, the word SHALL be dropped: contents, pointers and count unchanged, and overflow set to 1 on that edge.
REQ-023 When empty=1, out_ready SHALL have no effect and pointers SHALL NOT move.
REQ-024 A pop SHALL NOT occur when count=0, even if in_valid=1 in the same cycle; the word is pushed and appears next cycle.
REQ-025 overflow SHALL stay 1 until an edge with clear_overflow=1; if a drop and clear_overflow=1 fall on the same edge, the drop takes priority and overflow stays 1.
REQ-026 Ordering SHALL be strict FIFO; no word is duplicated or reordered.
REQ-027 out_result SHALL be undefined-but-stable while out_valid=0; consumers ignore it.

Reset
REQ-028 While rst=1: pointers=0, count=0, empty=1, full=0, out_valid=0, overflow=0, asynchronously.
REQ-029 Storage contents SHALL NOT be reset.
REQ-030 Reset mid-operation SHALL discard all stored words; the first push after deassertion SHALL be presented as the first output.

Verification
REQ-031 Single word: with DEPTH=8 and out_ready=0, push 0x0000002A -> out_valid=1 and out_result=0x0000002A next cycle, count=1; then raise out_ready for one cycle -> empty=1.
REQ-032 Fill and overflow: push 9 words 1..9 back to back with out_ready=0 -> full=1 after the 8th, overflow=1 after the 9th, pops return 1..8 and never 9.
REQ-033 Full with simultaneous push and pop: when full=1, in_valid=1 and out_ready=1 -> count stays 8, overflow stays 0, last pop order ends with the new word.
REQ-034 Wrap-around: run 20 words through with random out_ready -> output sequence equals input sequence, and count never exceeds 8.
REQ-035 Clear priority: drop while clear_overflow=1 -> overflow=1; next edge with clear_overflow=1 and no drop -> overflow=0.
REQ-036 Reset mid-stream: with count=5, pulse rst asynchronously -> empty=1 and out_valid=0 immediately; push 0x7 after deassertion -> out_result=0x7.
